// File: rtl/bic_pkg.sv
// Shared types and helpers for the bic serial receive/transmit path.
// The PARITY state exists only when BIC_PARITY_EN is defined.
package bic_pkg;

    localparam int BIC_DATA_BITS     = 8;
    localparam int BIC_OVERSAMPLE    = 16;
    localparam int BIC_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef BIC_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } bic_state_t;

    // Expected parity bit for a zero-extended character: even parity is the XOR of the data.
    function automatic logic bic_parity(input logic [BIC_MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/bic_sync2.sv
// Two-flop synchroniser for an asynchronous line that idles high; reset loads 1.
module bic_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make r_meta and r_sync two real flops in series.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/bic_sr_receiver.sv
// Oversampled serial character receiver: start-bit glitch rejection, mid-bit sampling,
// framing-error reporting. Define BIC_PARITY_EN to add a parity bit and parityErr.
module bic_sr_receiver
    import bic_pkg::*;
#(
    parameter int DATA_BITS  = BIC_DATA_BITS,
    parameter int OVERSAMPLE = BIC_OVERSAMPLE,
    parameter int PARITY_ODD = 0
) (
    input  logic                 srClock,
    input  logic                 rst,
    input  logic                 recEn,
    input  logic                 serialIn,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 charRec,
    output logic                 frameErr,
    output logic                 parityErr,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST      = BW'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > BIC_MAX_DATA_BITS || OVERSAMPLE < 4 ||
            (OVERSAMPLE % 2) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
            $error("bic_sr_receiver: unsupported DATA_BITS/OVERSAMPLE/PARITY_ODD");
        end
    endgenerate

    logic                 w_line_s;
    bic_state_t           r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_char_rec;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_par_bad;

    bic_sync2 u_sync (
        .i_clk   (srClock),
        .i_rst_n (rst),
        .i_d     (serialIn),
        .o_q     (w_line_s)
    );

`ifdef BIC_PARITY_EN
    logic [BIC_MAX_DATA_BITS-1:0] w_par_data;

    // NOTE: default-assign every always_comb output first so no path can infer a latch.
    always_comb begin
        w_par_data                  = '0;
        w_par_data[DATA_BITS-1:0]   = r_shift;
    end
`endif

    // NOTE: r_shift is left out of reset; it is fully rewritten before dataOut ever loads it.
    always_ff @(posedge srClock) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_data       <= '0;
            r_char_rec   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
        end else begin
            r_char_rec   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            if (r_state != S_IDLE && !recEn) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (recEn && !w_line_s) begin
                            r_state <= S_START;
                            r_cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (r_cnt == CNT_HALF_LAST) begin
                            if (!w_line_s) begin
                                r_state <= S_DATA;
                                r_cnt   <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (r_cnt == CNT_BIT_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {w_line_s, r_shift[DATA_BITS-1:1]};
                            r_par_bad <= 1'b0;
                            if (r_bit == IDX_LAST) begin
`ifdef BIC_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`ifdef BIC_PARITY_EN
                    S_PARITY: begin
                        if (r_cnt == CNT_BIT_LAST) begin
                            r_cnt     <= '0;
                            r_par_bad <= (w_line_s != bic_parity(w_par_data, PARITY_ODD != 0));
                            r_state   <= S_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
`endif
                    S_STOP: begin
                        if (r_cnt == CNT_BIT_LAST) begin
                            r_cnt  <= '0;
                            r_data <= r_shift;
                            if (w_line_s) begin
                                r_state      <= S_IDLE;
                                r_char_rec   <= !r_par_bad;
                                r_parity_err <= r_par_bad;
                            end else begin
                                r_state     <= S_WAIT_HIGH;
                                r_frame_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_WAIT_HIGH: begin
                        if (w_line_s) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign dataOut  = r_data;
    assign charRec  = r_char_rec;
    assign frameErr = r_frame_err;
    assign busy     = (r_state != S_IDLE);
`ifdef BIC_PARITY_EN
    assign parityErr = r_parity_err;
`else
    assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_bic_sr_receiver.sv
// Self-checking bench for bic_sr_receiver: directed table, corner sequences, and a
// randomized line checked against a frame-level reference model.
module tb_bic_sr_receiver;

    localparam int DB = 8;
    localparam int OS = 16;
    localparam int H  = OS / 2;
`ifdef BIC_PARITY_EN
    localparam int P  = 1;
`else
    localparam int P  = 0;
`endif
    localparam bit ODD        = 1'b0;
    localparam int STOP_EDGE  = H + (DB + 1 + P) * OS;
    localparam int FRAME_LEN  = (DB + 2 + P) * OS;
    localparam int L          = 4;
    localparam int SI         = L + 2 + STOP_EDGE;
    localparam int NR         = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       recEn = 1'b1;
    logic       serialIn = 1'b1;
    logic [7:0] dataOut;
    logic       charRec, frameErr, parityErr, busy;

    int n_tests = 0;
    int n_fail  = 0;

    bic_sr_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
        .srClock   (clk),
        .rst       (rst),
        .recEn     (recEn),
        .serialIn  (serialIn),
        .dataOut   (dataOut),
        .charRec   (charRec),
        .frameErr  (frameErr),
        .parityErr (parityErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { bit ser; bit en; bit rn; } cyc_t;
    typedef struct { logic [7:0] data; bit stop; int hold; bit exp_char; bit exp_ferr; } vec_t;

    cyc_t       wave[$];
    bit         obs_char[$], obs_ferr[$], obs_perr[$], obs_busy[$];
    logic [7:0] obs_data[$];

    bit         rs[NR];
    bit         exp_char[NR], exp_ferr[NR], exp_perr[NR], exp_busy[NR], exp_load[NR];
    logic [7:0] exp_val[NR], exp_data[NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_n(input bit ser, input int n);
        repeat (n) wave.push_back('{ser: ser, en: 1'b1, rn: 1'b1});
    endtask

    task automatic push_frame(input logic [7:0] d, input bit stop, input bit bad_par);
        push_n(1'b0, OS);
        for (int i = 0; i < DB; i++) push_n(d[i], OS);
`ifdef BIC_PARITY_EN
        push_n((^d) ^ ODD ^ bad_par, OS);
`else
        if (bad_par) push_n(1'b1, 0);
`endif
        push_n(stop, OS);
    endtask

    // Drives one wave entry before each rising edge and records outputs after it.
    task automatic apply_wave();
        obs_char.delete(); obs_ferr.delete(); obs_perr.delete(); obs_busy.delete(); obs_data.delete();
        foreach (wave[j]) begin
            serialIn = wave[j].ser;
            recEn    = wave[j].en;
            rst      = wave[j].rn;
            @(posedge clk);
            @(negedge clk);
            obs_char.push_back(charRec);
            obs_ferr.push_back(frameErr);
            obs_perr.push_back(parityErr);
            obs_busy.push_back(busy);
            obs_data.push_back(dataOut);
        end
        wave.delete();
        rst = 1'b1; recEn = 1'b1; serialIn = 1'b1;
    endtask

    function automatic int count_ones(input bit q[$]);
        int c = 0;
        foreach (q[i]) c += int'(q[i]);
        return c;
    endfunction

    function automatic int first_one(input bit q[$], input int from);
        for (int i = from; i < q.size(); i++) if (q[i]) return i;
        return -1;
    endfunction

    // Synchronised line as seen at edge e: two cycles behind the driven value, idle high before.
    function automatic bit line_at(input int e);
        return (e < 2) ? 1'b1 : rs[e-2];
    endfunction

    // Frame-level reference: walk the line, locate start edges, read mid-bit samples by arithmetic.
    task automatic run_model();
        int e = 0;
        int t0, ts, w;
        logic [7:0] d;
        bit bad;
        logic [7:0] cur = 8'h00;
        for (int k = 0; k < NR; k++) begin
            exp_char[k] = 0; exp_ferr[k] = 0; exp_perr[k] = 0; exp_busy[k] = 0; exp_load[k] = 0; exp_val[k] = 0;
        end
        while (e < NR) begin
            if (line_at(e)) begin
                e++;
            end else begin
                t0 = e;
                if (t0 + STOP_EDGE + 2 >= NR) break;
                if (line_at(t0 + H)) begin
                    for (int k = t0; k < t0 + H; k++) exp_busy[k] = 1;
                    e = t0 + H + 1;
                end else begin
                    d = 8'h00;
                    for (int i = 0; i < DB; i++) d[i] = line_at(t0 + H + (i + 1) * OS);
                    bad = 1'b0;
`ifdef BIC_PARITY_EN
                    bad = (line_at(t0 + H + (DB + 1) * OS) != ((^d) ^ ODD));
`endif
                    ts = t0 + STOP_EDGE;
                    for (int k = t0; k < ts; k++) exp_busy[k] = 1;
                    exp_load[ts] = 1;
                    exp_val[ts]  = d;
                    if (line_at(ts)) begin
                        if (bad) exp_perr[ts] = 1; else exp_char[ts] = 1;
                        e = ts + 1;
                    end else begin
                        exp_ferr[ts] = 1;
                        w = ts + 1;
                        while (w < NR && !line_at(w)) w++;
                        for (int k = ts; k < w && k < NR; k++) exp_busy[k] = 1;
                        e = w + 1;
                    end
                end
            end
        end
        for (int k = 0; k < NR; k++) begin
            if (exp_load[k]) cur = exp_val[k];
            exp_data[k] = cur;
        end
    endtask

    initial begin
        vec_t vt[6];
        logic [7:0] prev;
        int hs, ri, fs, a, b, jdrop, kind;
        logic [7:0] rd;

        vt[0] = '{data: 8'hA5, stop: 1'b1, hold: 0,  exp_char: 1'b1, exp_ferr: 1'b0};
        vt[1] = '{data: 8'h3C, stop: 1'b0, hold: 40, exp_char: 1'b0, exp_ferr: 1'b1};
        vt[2] = '{data: 8'h00, stop: 1'b1, hold: 0,  exp_char: 1'b1, exp_ferr: 1'b0};
        vt[3] = '{data: 8'hFF, stop: 1'b1, hold: 0,  exp_char: 1'b1, exp_ferr: 1'b0};
        vt[4] = '{data: 8'h5A, stop: 1'b1, hold: 0,  exp_char: 1'b1, exp_ferr: 1'b0};
        vt[5] = '{data: 8'h81, stop: 1'b0, hold: 0,  exp_char: 1'b0, exp_ferr: 1'b1};

        @(negedge clk);

        // Reset state
        wave.push_back('{ser: 1'b1, en: 1'b1, rn: 1'b0});
        wave.push_back('{ser: 1'b1, en: 1'b1, rn: 1'b0});
        push_n(1'b1, 4);
        apply_wave();
        check("reset dataOut", obs_data[1], 8'h00);
        check("reset strobes/busy", {obs_char[1], obs_ferr[1], obs_perr[1], obs_busy[1]}, 4'b0000);
        prev = 8'h00;

        // Table-driven frames
        foreach (vt[i]) begin
            push_n(1'b1, L);
            push_frame(vt[i].data, vt[i].stop, 1'b0);
            if (!vt[i].stop) push_n(1'b0, vt[i].hold);
            push_n(1'b1, 30);
            apply_wave();
            check($sformatf("vec%0d charRec count", i), count_ones(obs_char), vt[i].exp_char);
            check($sformatf("vec%0d frameErr count", i), count_ones(obs_ferr), vt[i].exp_ferr);
            check($sformatf("vec%0d parityErr count", i), count_ones(obs_perr), 0);
            check($sformatf("vec%0d strobe at stop edge", i), {obs_char[SI], obs_ferr[SI]}, {vt[i].exp_char, vt[i].exp_ferr});
            check($sformatf("vec%0d dataOut before stop", i), obs_data[SI-1], prev);
            check($sformatf("vec%0d dataOut at stop", i), obs_data[SI], vt[i].data);
            check($sformatf("vec%0d busy before stop", i), obs_busy[SI-1], 1);
            if (vt[i].stop) begin
                check($sformatf("vec%0d busy falls at stop", i), obs_busy[SI], 0);
            end else begin
                hs = L + FRAME_LEN + vt[i].hold;
                check($sformatf("vec%0d busy held while low", i), obs_busy[hs+1], 1);
                check($sformatf("vec%0d busy falls after line rises", i), obs_busy[hs+2], 0);
            end
            prev = vt[i].data;
        end

        // Start glitch: 4 low cycles
        push_n(1'b1, L);
        push_n(1'b0, 4);
        push_n(1'b1, 40);
        apply_wave();
        check("glitch strobes", count_ones(obs_char) + count_ones(obs_ferr) + count_ones(obs_perr), 0);
        check("glitch busy cycles", count_ones(obs_busy), H);
        check("glitch dataOut unchanged", obs_data[obs_data.size()-1], prev);

        // recEn dropped mid bit 3 of 0xFF
        push_n(1'b1, L);
        push_frame(8'hFF, 1'b1, 1'b0);
        push_n(1'b1, 30);
        jdrop = L + 4 * OS + H;
        wave[jdrop].en = 1'b0;
        apply_wave();
        check("recEn drop busy before", obs_busy[jdrop-1], 1);
        check("recEn drop busy after", obs_busy[jdrop], 0);
        check("recEn drop no strobe", count_ones(obs_char) + count_ones(obs_ferr) + count_ones(obs_perr), 0);
        check("recEn drop dataOut kept", obs_data[obs_data.size()-1], prev);

        // Reset mid bit 5, then clean 0x5A
        rd = 8'hC3;
        push_n(1'b1, L);
        push_n(1'b0, OS);
        for (int i = 0; i < 5; i++) push_n(rd[i], OS);
        push_n(rd[5], H);
        ri = wave.size();
        wave.push_back('{ser: 1'b1, en: 1'b1, rn: 1'b0});
        push_n(1'b1, 20);
        fs = wave.size();
        push_frame(8'h5A, 1'b1, 1'b0);
        push_n(1'b1, 30);
        apply_wave();
        check("mid reset dataOut before", obs_data[ri-1], prev);
        check("mid reset busy before", obs_busy[ri-1], 1);
        check("mid reset outputs cleared", {obs_data[ri], obs_char[ri], obs_ferr[ri], obs_perr[ri], obs_busy[ri]}, 12'h000);
        check("after reset charRec count", count_ones(obs_char), 1);
        check("after reset charRec edge", obs_char[fs + 2 + STOP_EDGE], 1);
        check("after reset dataOut", obs_data[fs + 2 + STOP_EDGE], 8'h5A);
        prev = 8'h5A;

        // Back-to-back 0x00 then 0xFF
        push_n(1'b1, L);
        push_frame(8'h00, 1'b1, 1'b0);
        push_frame(8'hFF, 1'b1, 1'b0);
        push_n(1'b1, 30);
        apply_wave();
        a = first_one(obs_char, 0);
        b = (a < 0) ? -1 : first_one(obs_char, a + 1);
        check("b2b charRec count", count_ones(obs_char), 2);
        check("b2b first edge", a, SI);
        check("b2b spacing", b - a, FRAME_LEN);
        check("b2b first data", (a < 0) ? 32'hDEAD : {24'h0, obs_data[a]}, 8'h00);
        check("b2b second data", (b < 0) ? 32'hDEAD : {24'h0, obs_data[b]}, 8'hFF);
        prev = 8'hFF;

`ifdef BIC_PARITY_EN
        push_n(1'b1, L);
        push_frame(8'h01, 1'b1, 1'b1);
        push_n(1'b1, 30);
        apply_wave();
        check("bad parity parityErr count", count_ones(obs_perr), 1);
        check("bad parity parityErr edge", obs_perr[SI], 1);
        check("bad parity no charRec", count_ones(obs_char), 0);
        check("bad parity dataOut", obs_data[SI], 8'h01);
        push_n(1'b1, L);
        push_frame(8'h01, 1'b1, 1'b0);
        push_n(1'b1, 30);
        apply_wave();
        check("good parity charRec edge", obs_char[SI], 1);
        check("good parity no parityErr", count_ones(obs_perr), 0);
`endif

        // Randomized line against the reference model
        wave.push_back('{ser: 1'b1, en: 1'b1, rn: 1'b0});
        wave.push_back('{ser: 1'b1, en: 1'b1, rn: 1'b0});
        apply_wave();
        check("random pre-reset dataOut", obs_data[1], 8'h00);
        push_n(1'b1, 6);
        while (wave.size() < NR - 400) begin
            kind = $urandom_range(0, 9);
            rd   = 8'($urandom);
            if (kind == 0) begin
                push_n(1'b0, $urandom_range(1, 6));
                push_n(1'b1, $urandom_range(2, 20));
            end else if (kind == 1) begin
                push_frame(rd, 1'b0, 1'b0);
                push_n(1'b0, $urandom_range(0, 30));
                push_n(1'b1, $urandom_range(1, 20));
            end else begin
                push_frame(rd, 1'b1, $urandom_range(0, 7) == 0);
                push_n(1'b1, $urandom_range(0, 20));
            end
        end
        push_n(1'b1, NR - wave.size());
        foreach (wave[j]) rs[j] = wave[j].ser;
        run_model();
        apply_wave();
        for (int j = 0; j < NR; j++) begin
            check($sformatf("rand edge %0d {chr,fer,per,bsy,data}", j),
                  {obs_char[j], obs_ferr[j], obs_perr[j], obs_busy[j], obs_data[j]},
                  {exp_char[j], exp_ferr[j], exp_perr[j], exp_busy[j], exp_data[j]});
        end
        check("random saw characters", count_ones(obs_char) > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bic_sr_receiver.md
# bic_sr_receiver

Parametrised serial character receiver for the chat link; next generation of the bit-in-character receive path. Runs on the oversampling `srClock`, detects a start bit, samples each bit at mid-bit, checks the stop bit, and presents the assembled character with a one-cycle `charRec` strobe. Generalises the fixed 10-bit frame to configurable data width and oversample ratio. Adds glitch rejection, framing-error reporting and optional parity.

## Interface
- DATA_BITS, 8, data bits per character (5..9), LSB first
- OVERSAMPLE, 16, `srClock` cycles per bit; even, at least 4
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with BIC_PARITY_EN
- srClock  in  1  sole clock, rising edge
- rst  in  1  reset; synchronous, active-low
- recEn  in  1  receive enable
- serialIn  in  1  asynchronous serial line, idle high
- dataOut  out  DATA_BITS  last received character
- charRec  out  1  one-cycle strobe: good character on `dataOut`
- frameErr  out  1  one-cycle strobe: stop bit sampled low
- parityErr  out  1  one-cycle strobe: parity mismatch; constant 0 without BIC_PARITY_EN
- busy  out  1  high in every state except IDLE

## Operation
- `serialIn` passes through a 2-flop synchroniser; `lineS` is the synchronised line. All state decisions use `lineS`.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: when `recEn`=1 and `lineS`=0, go to START and clear the sample counter.
- START: count OVERSAMPLE/2 cycles, then resample.
  - `lineS`=0: go to DATA, clear the counter and the bit index.
  - `lineS`=1: glitch; return to IDLE with no strobe.
- DATA: every OVERSAMPLE cycles, shift `lineS` into the MSB of the shift register (LSB-first). After DATA_BITS samples, go to PARITY or STOP.
- PARITY: after OVERSAMPLE cycles, sample the parity bit and compare with the XOR of the data, inverted if PARITY_ODD.
- STOP: after OVERSAMPLE cycles, sample the stop bit.
  - 1: load `dataOut`. Assert `charRec`, or assert `parityErr` instead if parity failed. Go to IDLE.
  - 0: load `dataOut`, assert `frameErr`, go to WAIT_HIGH.
- WAIT_HIGH: stay until `lineS`=1, then go to IDLE. A break condition therefore yields exactly one `frameErr`.
- `recEn`=0 in any non-IDLE state: return to IDLE on the next edge. No strobe; `dataOut` is unchanged.
- Never more than one strobe per frame. Strobes are mutually exclusive.

## Timing
- Reset (`rst`=0 at an edge): state IDLE, counters 0, synchroniser flops 1. `dataOut`=0; `charRec`, `frameErr`, `parityErr` and `busy` all 0. This applies mid-frame; the partial character is discarded.
- Edge 0 is the edge at which IDLE sees `lineS`=0. The start bit is resampled at edge OVERSAMPLE/2.
- Data bit i (0-based) is sampled at edge OVERSAMPLE/2 + (i+1)·OVERSAMPLE.
- The stop bit is sampled at edge OVERSAMPLE/2 + (DATA_BITS+1+P)·OVERSAMPLE, where P=1 with parity and 0 without.
- Defaults (8 data bits, OVERSAMPLE 16, no parity): stop sampled at edge 152. The strobe and the `dataOut` update occur at that same edge and are visible for exactly one cycle.
- `serialIn` to `lineS` latency: 2 cycles.
- Back-to-back frames: a start edge arriving in the cycle after the return to IDLE is accepted.
- The sample counter is $clog2(OVERSAMPLE) bits wide and wraps to 0 at OVERSAMPLE-1. The bit index is $clog2(DATA_BITS+1) bits wide.

## Configuration
- BIC_PARITY_EN defined:
  - PARITY state is compiled in and the frame is 1 bit longer.
  - `parityErr` is live.
  - A character with bad parity is loaded into `dataOut` without `charRec`.
- BIC_PARITY_EN undefined:
  - No PARITY state; `parityErr` is tied to 0.
  - PARITY_ODD is ignored.

## Structure
- Package `bic_pkg`: state enum `bic_state_t`, the default constants BIC_DATA_BITS and BIC_OVERSAMPLE, and a parity helper function.
- Sub-module `bic_sync2`: 2-flop synchroniser with reset value 1, reusable by the transmit side.
- FSM, counters and shift register live in `bic_sr_receiver`.

## Test plan
All scenarios use the defaults, with `recEn`=1 unless stated.
- Frame 0xA5 with stop=1 -> `dataOut`=8'hA5, `charRec` high for 1 cycle at the edge the stop bit is sampled (edge 152 of the frame timeline); `frameErr`=0; `busy` falls on that edge.
- `serialIn` low for 4 cycles, then high -> START rejects it as a glitch, returns to IDLE, no strobe, `dataOut` unchanged.
- Frame 0x3C with stop=0, line held low 40 cycles -> one `frameErr` pulse, `dataOut`=8'h3C, `busy` stays high until `lineS` rises.
- Drop `recEn` during bit 3 of 0xFF -> IDLE next edge, no strobe, `dataOut` keeps its prior value.
- Assert `rst` low during bit 5 -> all outputs 0 at the next edge; the following clean frame 0x5A is received correctly.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `charRec` pulses, 160 cycles apart. With BIC_PARITY_EN, bad parity on 0x01 -> `parityErr` pulse and no `charRec`.
